// File: rtl/cdu_pulse_arbiter_if.sv
// Request/pulse bundle between the CDU angle-channel read logic
// and the shared AGC counter-pulse arbiter.
interface cdu_pulse_arbiter_if #(
    parameter int NCH = 5
);
    logic [NCH-1:0] up_req;
    logic [NCH-1:0] dn_req;
    logic [NCH-1:0] ovf_clr;
    logic           pls_up;
    logic           pls_dn;
    logic [2:0]     pls_ch;
    logic           busy;
    logic [NCH-1:0] ovf;

    modport master (
        output up_req,
        output dn_req,
        output ovf_clr,
        input  pls_up,
        input  pls_dn,
        input  pls_ch,
        input  busy,
        input  ovf
    );

    modport slave (
        input  up_req,
        input  dn_req,
        input  ovf_clr,
        output pls_up,
        output pls_dn,
        output pls_ch,
        output busy,
        output ovf
    );
endinterface

// File: rtl/cdu_pulse_arbiter.sv
// Nets per-channel up/down increment requests into saturating pending
// counts and drains them as one AGC pulse per slot, round-robin.
module cdu_pulse_arbiter #(
    parameter int NCH      = 5,
    parameter int CNT_W    = 4,
    parameter int SLOT_DIV = 16
) (
    input logic              CLOCKH,
    input logic              rst,
    cdu_pulse_arbiter_if.slave bus
);
    localparam int SW = (SLOT_DIV > 2) ? $clog2(SLOT_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_DIV - 1);
    localparam logic signed [CNT_W:0] ONE  = (CNT_W+1)'(1);
    localparam logic signed [CNT_W:0] SMAX =
        (CNT_W+1)'((1 << (CNT_W - 1)) - 1);
    localparam logic signed [CNT_W:0] SMIN = -SMAX;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SW-1:0] slot_q;
    logic          tick;

    logic signed [CNT_W-1:0] cnt_q [NCH];
    logic signed [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]          sat;
    logic [NCH-1:0]          nz;
    logic [NCH-1:0]          ovf_q;

    logic [2:0] last_q;
    logic [2:0] sel_idx;
    logic       found;
    logic       sel_pos;
    logic       gnt_vld;

    logic       pls_up_q;
    logic       pls_dn_q;
    logic [2:0] pls_ch_q;

    assign tick = (slot_q == SLOT_LAST);

    // Round-robin search from the channel after the last grant,
    // using only counts registered before this cycle.
    always_comb begin
        logic [2:0] cand;
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = 3'((int'(last_q) + 1 + k) % NCH);
            if (!found && (cnt_q[cand] != '0)) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_pos = !cnt_q[sel_idx][CNT_W-1];

    always_comb begin
        state_d = state_q;
        gnt_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && found) begin
                    gnt_vld = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
        endcase
    end

    // One extra bit of headroom so the clamp sees the true sum.
    always_comb begin
        logic signed [CNT_W:0] s;
        s   = '0;
        sat = '0;
        for (int i = 0; i < NCH; i++) begin
            s = {cnt_q[i][CNT_W-1], cnt_q[i]};
            if (bus.up_req[i]) begin
                s = s + ONE;
            end
            if (bus.dn_req[i]) begin
                s = s - ONE;
            end
            if (gnt_vld && (sel_idx == 3'(i))) begin
                s = sel_pos ? (s - ONE) : (s + ONE);
            end
            if (s > SMAX) begin
                s      = SMAX;
                sat[i] = 1'b1;
            end else if (s < SMIN) begin
                s      = SMIN;
                sat[i] = 1'b1;
            end
            cnt_d[i] = s[CNT_W-1:0];
        end
    end

    always_comb begin
        nz = '0;
        for (int i = 0; i < NCH; i++) begin
            nz[i] = (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            last_q   <= 3'(NCH - 1);
            ovf_q    <= '0;
            pls_up_q <= 1'b0;
            pls_dn_q <= 1'b0;
            pls_ch_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            slot_q   <= tick ? '0 : slot_q + 1'b1;
            ovf_q    <= (ovf_q & ~bus.ovf_clr) | sat;
            pls_up_q <= gnt_vld && sel_pos;
            pls_dn_q <= gnt_vld && !sel_pos;
            if (gnt_vld) begin
                last_q   <= sel_idx;
                pls_ch_q <= sel_idx;
            end
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.pls_up = pls_up_q;
    assign bus.pls_dn = pls_dn_q;
    assign bus.pls_ch = pls_ch_q;
    assign bus.busy   = |nz;
    assign bus.ovf    = ovf_q;

endmodule
